// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Watchdog counter width; wide enough for MAX_WAIT up to 255.
    localparam int WAIT_CW = 8;

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for an outstanding memory access: counts cycles while enabled and
// flags expiry on the MAX_WAIT-th enabled cycle.
module arb_watchdog
    import arb_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WAIT_CW-1:0] LAST_CNT = WAIT_CW'(MAX_WAIT - 1);

    logic [WAIT_CW-1:0] cnt_q;
    logic [WAIT_CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed enabled cycles, so LAST_CNT marks the final one.
    assign expire_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// State table:
//   IDLE | no access outstanding; grants are issued here
//   WAIT | mem_req asserted, waiting for mem_ack or watchdog expiry
//   RESP | one-cycle completion pulse to the owning side
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_gnt_o,
    output logic          dm_rvalid_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic          err_o
);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;
    arb_owner_t    last_q, last_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          grant_if, grant_dm;
    logic          wd_expire;

    arb_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q != WAIT),
        .enable_i (state_q == WAIT),
        .expire_o (wd_expire)
    );

    // Round-robin grant; depends only on requests and state, never on mem_ack.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == IDLE) begin
            if (if_req_i && dm_req_i) begin
                if (last_q == OWN_IF) begin
                    grant_dm = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else if (dm_req_i) begin
                grant_dm = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    // Next-state, request latching and response capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = WAIT;
                    owner_d     = OWN_DM;
                    last_d      = OWN_DM;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (grant_if) begin
                    state_d     = WAIT;
                    owner_d     = OWN_IF;
                    last_d      = OWN_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                end
            end
            WAIT: begin
                // An ack on the expiry cycle still completes normally.
                if (mem_ack_i) begin
                    state_d = RESP;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = mem_we_q ? '0 : mem_rdata_i;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                    end
                end else if (wd_expire) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign if_gnt_o    = grant_if;
    assign dm_gnt_o    = grant_dm;
    assign if_rvalid_o = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_rvalid_o = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = (state_q == WAIT);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// accesses, checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, dm_req, dm_we, mem_ack;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic          mem_req, mem_we, busy, err;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    // Model state: who was granted last, and the last data returned to each side.
    bit            last_dm;
    logic [DW-1:0] exp_if_rd, exp_dm_rd;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW (AW), .DW (DW), .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_gnt_o    (dm_gnt),
        .dm_rvalid_o (dm_rvalid),
        .dm_rdata_o  (dm_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one access starting in an IDLE cycle with requests already settled.
    // delay = WAIT cycle (1-based) on which mem_ack arrives; outside 1..MAX_WAIT = never.
    task automatic serve(input int delay, input logic [DW-1:0] rdat);
        bit            win_dm, acked;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        win_dm = (if_req && dm_req) ? !last_dm : dm_req;
        acked  = (delay >= 1) && (delay <= MAX_WAIT);
        check("busy_idle", busy, 1'b0);
        check("dm_gnt", dm_gnt, win_dm);
        check("if_gnt", if_gnt, !win_dm);
        e_we   = win_dm ? dm_we : 1'b0;
        e_addr = win_dm ? dm_addr : if_addr;
        e_wd   = win_dm ? dm_wdata : '0;
        last_dm = win_dm;
        @(negedge clk);
        if (win_dm) dm_req = 1'b0; else if_req = 1'b0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            if (k == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdat;
            end
            #1;
            check("wait_mem_req", mem_req, 1'b1);
            check("wait_mem_we", mem_we, e_we);
            check("wait_mem_addr", mem_addr, e_addr);
            check("wait_mem_wdata", mem_wdata, e_wd);
            check("wait_gnt", {if_gnt, dm_gnt}, 2'b00);
            check("wait_rvalid", {if_rvalid, dm_rvalid, err}, 3'b000);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (k == delay) break;
        end
        if (win_dm) exp_dm_rd = (acked && !e_we) ? rdat : '0;
        else        exp_if_rd = acked ? rdat : '0;
        #1;
        check("resp_mem_req", mem_req, 1'b0);
        check("resp_gnt", {if_gnt, dm_gnt}, 2'b00);
        check("resp_rvalid", {if_rvalid, dm_rvalid}, win_dm ? 2'b01 : 2'b10);
        check("resp_err", err, !acked);
        check("resp_if_rdata", if_rdata, exp_if_rd);
        check("resp_dm_rdata", dm_rdata, exp_dm_rd);
        @(negedge clk);
        #1;
        check("post_busy", busy, 1'b0);
        check("post_pulse", {if_rvalid, dm_rvalid, err}, 3'b000);
        check("hold_if_rdata", if_rdata, exp_if_rd);
        check("hold_dm_rdata", dm_rdata, exp_dm_rd);
    endtask

    initial begin
        int p, d;
        rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        last_dm = 1'b0; exp_if_rd = '0; exp_dm_rd = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outputs", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, busy, err}, 8'h00);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata", if_rdata | dm_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // IF-only fetch, ack on the first WAIT cycle.
        if_req = 1; if_addr = 32'h0000_0010; #1;
        serve(1, 32'h0050_0093);

        // Collision after reset: DM wins, then IF, then alternating.
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h14; #1;
        serve(1, 32'h1111_0000);
        serve(2, 32'h2222_0000);
        for (int i = 0; i < 4; i++) begin
            dm_req = 1; dm_addr = $urandom; if_req = 1; if_addr = $urandom; #1;
            serve(1, $urandom);
            serve(1, $urandom);
        end

        // Store, mem_req held four cycles, dm_rdata returns 0.
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFE_F00D; #1;
        serve(4, 32'hDEAD_BEEF);

        // No ack: watchdog abort.
        dm_we = 0; if_req = 1; if_addr = 32'h40; #1;
        serve(0, 32'h0);

        // Ack on the final WAIT cycle completes normally.
        dm_req = 1; dm_addr = 32'h300; #1;
        serve(MAX_WAIT, 32'h1234_5678);

        // Reset in the middle of WAIT.
        dm_req = 1; dm_addr = 32'h500; #1;
        check("pre_rst_gnt", dm_gnt, 1'b1);
        @(negedge clk);
        dm_req = 0; #1;
        check("pre_rst_mem_req", mem_req, 1'b1);
        rst_n = 1'b0; #1;
        check("rst_mid_outputs", {mem_req, busy, if_rvalid, dm_rvalid, err}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        last_dm = 1'b0; exp_if_rd = '0; exp_dm_rd = '0;
        #1;
        check("rst_mid_still_idle", {mem_req, busy, if_rvalid, dm_rvalid}, 4'b0000);
        dm_req = 1; dm_addr = 32'h600; if_req = 1; if_addr = 32'h60; #1;
        serve(1, $urandom);
        serve(1, $urandom);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(1, 3);
            if (p[0]) begin if_req = 1; if_addr = $urandom; end
            if (p[1]) begin dm_req = 1; dm_addr = $urandom; dm_we = $urandom_range(0, 1); dm_wdata = $urandom; end
            #1;
            while (if_req || dm_req) begin
                d = $urandom_range(1, MAX_WAIT + 3);
                serve(d, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
